// File: rtl/sap_controller.sv
// SAP instruction sequencer: T-state counter plus combinational control-line
// decode from T-state, IR opcode nibble and ALU flags.
module sap_controller #(
  parameter bit SKIP_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Opcode,
  input  logic       CarryFlag,
  input  logic       ZeroFlag,
  output logic       PCInc,
  output logic       PCOut,
  output logic       PCIn,
  output logic       MARIn,
  output logic       RAMOut,
  output logic       RAMIn,
  output logic       IRIn,
  output logic       IROut,
  output logic       AIn,
  output logic       AOut,
  output logic       BIn,
  output logic       ALUOut,
  output logic       Sub,
  output logic       FlagIn,
  output logic       OutIn,
  output logic [2:0] TState,
  output logic       Halted
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} tstate_e;
  typedef enum logic [3:0] {
    OpLda = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpSta = 4'h3,
    OpLdi = 4'h4, OpJmp = 4'h5, OpJc  = 4'h6, OpJz  = 4'h7,
    OpOut = 4'hE, OpHlt = 4'hF
  } opcode_e;

  tstate_e state;
  opcode_e op;
  logic    lastStep;

  assign op     = opcode_e'(Opcode);
  assign TState = state;

  always_comb begin
    lastStep = 1'b0;
    case (state)
      T2:      lastStep = !(op inside {OpLda, OpSta, OpAdd, OpSub});
      T3:      lastStep = op inside {OpLda, OpSta};
      T4:      lastStep = 1'b1;
      default: lastStep = 1'b0;
    endcase
    if (!SKIP_NOP) lastStep = (state == T4);
  end

  // HLT freezes the counter at T2; only reset leaves the halted condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T0;
      Halted <= 1'b0;
    end else if (!Halted) begin
      if (state == T2 && op == OpHlt) Halted <= 1'b1;
      else if (lastStep)              state  <= T0;
      else                            state  <= tstate_e'(state + 3'd1);
    end
  end

  always_comb begin
    PCInc  = 1'b0; PCOut  = 1'b0; PCIn   = 1'b0; MARIn = 1'b0;
    RAMOut = 1'b0; RAMIn  = 1'b0; IRIn   = 1'b0; IROut = 1'b0;
    AIn    = 1'b0; AOut   = 1'b0; BIn    = 1'b0; ALUOut = 1'b0;
    Sub    = 1'b0; FlagIn = 1'b0; OutIn  = 1'b0;
    if (rst && !Halted) begin
      case (state)
        T0: begin PCOut = 1'b1; MARIn = 1'b1; end
        T1: begin RAMOut = 1'b1; IRIn = 1'b1; PCInc = 1'b1; end
        T2: begin
          case (op)
            OpLda, OpAdd, OpSub, OpSta: begin IROut = 1'b1; MARIn = 1'b1; end
            OpLdi: begin IROut = 1'b1; AIn = 1'b1; end
            OpJmp: begin IROut = 1'b1; PCIn = 1'b1; end
            OpJc:  begin IROut = CarryFlag; PCIn = CarryFlag; end
            OpJz:  begin IROut = ZeroFlag;  PCIn = ZeroFlag;  end
            OpOut: begin AOut = 1'b1; OutIn = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OpLda:        begin RAMOut = 1'b1; AIn = 1'b1; end
            OpAdd, OpSub: begin RAMOut = 1'b1; BIn = 1'b1; end
            OpSta:        begin AOut = 1'b1; RAMIn = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (op inside {OpAdd, OpSub}) begin
            ALUOut = 1'b1; AIn = 1'b1; FlagIn = 1'b1;
            Sub    = (op == OpSub);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: one instance per SKIP_NOP setting,
// a per-cycle microcode-table reference model, vector table and corner sequences.
module tb_sap_controller;

  localparam logic [14:0] M_PCINC  = 15'h4000, M_PCOUT  = 15'h2000, M_PCIN   = 15'h1000;
  localparam logic [14:0] M_MARIN  = 15'h0800, M_RAMOUT = 15'h0400, M_RAMIN  = 15'h0200;
  localparam logic [14:0] M_IRIN   = 15'h0100, M_IROUT  = 15'h0080, M_AIN    = 15'h0040;
  localparam logic [14:0] M_AOUT   = 15'h0020, M_BIN    = 15'h0010, M_ALUOUT = 15'h0008;
  localparam logic [14:0] M_SUB    = 15'h0004, M_FLAGIN = 15'h0002, M_OUTIN  = 15'h0001;
  localparam logic [14:0] M_BUS    = M_PCOUT | M_RAMOUT | M_IROUT | M_AOUT | M_ALUOUT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       carry = 1'b0, zero = 1'b0;
  wire [14:0] ctrlA, ctrlB;
  wire [2:0]  tsA, tsB;
  wire        hlA, hlB;

  int nChecks = 0, nErr = 0;
  bit chkOn = 1'b0;

  always #5 clk = ~clk;

  sap_controller #(.SKIP_NOP(1'b1)) dutA (
    .clk(clk), .rst(rst), .Opcode(opcode), .CarryFlag(carry), .ZeroFlag(zero),
    .PCInc(ctrlA[14]), .PCOut(ctrlA[13]), .PCIn(ctrlA[12]), .MARIn(ctrlA[11]),
    .RAMOut(ctrlA[10]), .RAMIn(ctrlA[9]), .IRIn(ctrlA[8]), .IROut(ctrlA[7]),
    .AIn(ctrlA[6]), .AOut(ctrlA[5]), .BIn(ctrlA[4]), .ALUOut(ctrlA[3]),
    .Sub(ctrlA[2]), .FlagIn(ctrlA[1]), .OutIn(ctrlA[0]), .TState(tsA), .Halted(hlA));

  sap_controller #(.SKIP_NOP(1'b0)) dutB (
    .clk(clk), .rst(rst), .Opcode(opcode), .CarryFlag(carry), .ZeroFlag(zero),
    .PCInc(ctrlB[14]), .PCOut(ctrlB[13]), .PCIn(ctrlB[12]), .MARIn(ctrlB[11]),
    .RAMOut(ctrlB[10]), .RAMIn(ctrlB[9]), .IRIn(ctrlB[8]), .IROut(ctrlB[7]),
    .AIn(ctrlB[6]), .AOut(ctrlB[5]), .BIn(ctrlB[4]), .ALUOut(ctrlB[3]),
    .Sub(ctrlB[2]), .FlagIn(ctrlB[1]), .OutIn(ctrlB[0]), .TState(tsB), .Halted(hlB));

  // Reference model: execute-step microcode per opcode plus instruction length.
  logic [14:0] uc [16][3];
  int          lenTab [16];
  int          tM [2];
  bit          hM [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] expCtrl(input int i);
    logic [14:0] w;
    if (!rst || hM[i]) return '0;
    if (tM[i] == 0) return M_PCOUT | M_MARIN;
    if (tM[i] == 1) return M_RAMOUT | M_IRIN | M_PCINC;
    w = uc[opcode][tM[i] - 2];
    if ((opcode == 4'h6 && !carry) || (opcode == 4'h7 && !zero)) w = '0;
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        tM[i] <= 0;
        hM[i] <= 1'b0;
      end else if (!hM[i]) begin
        if (tM[i] == 2 && opcode == 4'hF)                   hM[i] <= 1'b1;
        else if (tM[i] + 1 >= ((i == 1) ? 5 : lenTab[opcode])) tM[i] <= 0;
        else                                                tM[i] <= tM[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      for (int i = 0; i < 2; i++) begin
        logic [14:0] c;
        logic [2:0]  t;
        logic        h;
        c = (i == 1) ? ctrlB : ctrlA;
        t = (i == 1) ? tsB : tsA;
        h = (i == 1) ? hlB : hlA;
        chk($sformatf("model_tstate%0d", i), t, tM[i]);
        chk($sformatf("model_halted%0d", i), h, hM[i]);
        chk($sformatf("model_ctrl%0d", i), c, expCtrl(i));
        chk($sformatf("one_bus_driver%0d", i), ($countones(c & M_BUS) > 1), 0);
        chk($sformatf("pcinc_only_t1_%0d", i), (c[14] && t != 3'd1), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    int          len;
    logic [14:0] t2;
  } vec_t;

  vec_t vt [14];
  int   seqA [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 0};
  int   len, haltCnt;
  logic [14:0] t2;

  initial begin
    for (int o = 0; o < 16; o++) begin
      lenTab[o] = 3;
      for (int s = 0; s < 3; s++) uc[o][s] = '0;
    end
    lenTab[0] = 4; lenTab[1] = 5; lenTab[2] = 5; lenTab[3] = 4;
    uc[0][0] = M_IROUT | M_MARIN;  uc[0][1] = M_RAMOUT | M_AIN;
    uc[1][0] = M_IROUT | M_MARIN;  uc[1][1] = M_RAMOUT | M_BIN;
    uc[1][2] = M_ALUOUT | M_AIN | M_FLAGIN;
    uc[2][0] = M_IROUT | M_MARIN;  uc[2][1] = M_RAMOUT | M_BIN;
    uc[2][2] = M_ALUOUT | M_AIN | M_FLAGIN | M_SUB;
    uc[3][0] = M_IROUT | M_MARIN;  uc[3][1] = M_AOUT | M_RAMIN;
    uc[4][0] = M_IROUT | M_AIN;
    uc[5][0] = M_IROUT | M_PCIN;
    uc[6][0] = M_IROUT | M_PCIN;
    uc[7][0] = M_IROUT | M_PCIN;
    uc[14][0] = M_AOUT | M_OUTIN;

    vt[0]  = '{4'h0, 1'b0, 1'b0, 4, M_IROUT | M_MARIN};
    vt[1]  = '{4'h1, 1'b0, 1'b0, 5, M_IROUT | M_MARIN};
    vt[2]  = '{4'h2, 1'b1, 1'b1, 5, M_IROUT | M_MARIN};
    vt[3]  = '{4'h3, 1'b0, 1'b0, 4, M_IROUT | M_MARIN};
    vt[4]  = '{4'h4, 1'b0, 1'b0, 3, M_IROUT | M_AIN};
    vt[5]  = '{4'h5, 1'b0, 1'b0, 3, M_IROUT | M_PCIN};
    vt[6]  = '{4'h6, 1'b1, 1'b0, 3, M_IROUT | M_PCIN};
    vt[7]  = '{4'h6, 1'b0, 1'b1, 3, 15'h0000};
    vt[8]  = '{4'h7, 1'b0, 1'b1, 3, M_IROUT | M_PCIN};
    vt[9]  = '{4'h7, 1'b1, 1'b0, 3, 15'h0000};
    vt[10] = '{4'hE, 1'b0, 1'b0, 3, M_AOUT | M_OUTIN};
    vt[11] = '{4'h8, 1'b1, 1'b1, 3, 15'h0000};
    vt[12] = '{4'hD, 1'b0, 1'b0, 3, 15'h0000};
    vt[13] = '{4'hB, 1'b1, 1'b0, 3, 15'h0000};

    #2 rst = 1'b0;
    chkOn = 1'b1;

    // Reset held for two cycles, then release into T0 fetch.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tstate", tsA, 0);
    chk("rst_halted", hlA, 0);
    chk("rst_ctrlA", ctrlA, 0);
    chk("rst_ctrlB", ctrlB, 0);
    rst = 1'b1;
    #1;
    chk("release_ctrlA", ctrlA, M_PCOUT | M_MARIN);
    chk("release_ctrlB", ctrlB, M_PCOUT | M_MARIN);

    for (int k = 0; k < 14; k++) begin
      resetDut();
      opcode = vt[k].op; carry = vt[k].c; zero = vt[k].z;
      len = 0; t2 = 'x;
      do begin
        #1;
        if (tsA == 3'd2) t2 = ctrlA;
        tick();
        len++;
      end while (tsA != 3'd0 && len < 10);
      chk($sformatf("vec%0d_len", k), len, vt[k].len);
      chk($sformatf("vec%0d_t2", k), t2, vt[k].t2);
    end

    // LDA followed by ADD, then by SUB.
    for (int s = 1; s <= 2; s++) begin
      resetDut();
      for (int i = 0; i < 10; i++) begin
        opcode = (i < 4) ? 4'h0 : 4'(s);
        #1;
        chk($sformatf("seq%0d_ts%0d", s, i), tsA, seqA[i]);
        if (i == 3) chk("lda_t3", ctrlA, M_RAMOUT | M_AIN);
        if (i == 7) chk("alu_t3", ctrlA, M_RAMOUT | M_BIN);
        if (i == 8) chk("alu_t4", ctrlA, M_ALUOUT | M_AIN | M_FLAGIN | ((s == 2) ? M_SUB : 15'h0));
        if (i != 8) chk("sub_only_t4", ctrlA[2], 0);
        tick();
      end
    end

    // SKIP_NOP=0 JMP runs all five T-states.
    resetDut();
    opcode = 4'h5;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("jmp_full_ts%0d", i), tsB, i % 5);
      if (i == 2) chk("jmp_full_t2", ctrlB, M_IROUT | M_PCIN);
      else        chk("jmp_full_pcin", ctrlB[12], 0);
      if (i == 3 || i == 4) chk("jmp_full_idle", ctrlB, 0);
      tick();
    end

    // HLT freezes at T2 until an asynchronous reset pulse.
    resetDut();
    opcode = 4'hF;
    tick(); tick();
    chk("hlt_pre_ts", tsA, 2);
    chk("hlt_pre_halted", hlA, 0);
    tick();
    chk("hlt_haltedA", hlA, 1);
    chk("hlt_haltedB", hlB, 1);
    for (int i = 0; i < 10; i++) begin
      opcode = 4'($urandom_range(0, 15));
      carry = 1'($urandom); zero = 1'($urandom);
      #1;
      chk("hlt_hold_ts", tsA, 2);
      chk("hlt_hold_tsB", tsB, 2);
      chk("hlt_hold_ctrl", ctrlA | ctrlB, 0);
      tick();
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("hlt_rst_halted", hlA, 0);
    chk("hlt_rst_ts", tsA, 0);
    chk("hlt_rst_haltedB", hlB, 0);
    #1 rst = 1'b1;
    tick();

    // Randomized traffic against the reference model.
    haltCnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (tM[0] < 2) begin
        opcode = 4'($urandom_range(0, 15));
        if (opcode == 4'hF && $urandom_range(0, 3) != 0) opcode = 4'hE;
      end
      carry = 1'($urandom);
      zero  = 1'($urandom);
      if (hM[0] || hM[1]) haltCnt++;
      if (haltCnt > 4 || $urandom_range(0, 63) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        haltCnt = 0;
      end
      tick();
    end

    @(negedge clk);
    chkOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
